transmitter: RTL and testbench

Serial UART transmit stage that produces the frame format consumed by the receive stage on the same link. It accepts 7-bit characters over a load/ready handshake and buffers them. It computes odd parity and shifts out one bit per `tx_en` tick: start, parity, `d[6:0]` MSB-first, then stop bit(s). It sits between the host-side character source and the `tx` line; `tx_en` comes from the shared bit-rate tick generator.

---
 rtl/transmitter_if.sv | 11 +
 rtl/transmitter.sv | 175 +++++++++++++++++
 tb/tb_transmitter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/transmitter_if.sv
// Host-side character handshake for the UART transmitter: 7-bit data, load request, ready.
interface transmitter_if;
  localparam int unsigned DATA_W = 7;

  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;

  modport master (output data_in, output load, input ready);
  modport slave  (input data_in, input load, output ready);
endinterface

// File: rtl/transmitter.sv
// UART transmit stage: buffers 7-bit characters and sends start, odd parity, d6..d0, stop bit(s).
// Define TRANSMITTER_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module transmitter #(
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         tx_en,
  transmitter_if.slave host,
  output logic         tx,
  output logic         busy,
  output logic         parity
);
  localparam int unsigned DATA_W     = 7;
  localparam int unsigned SHIFT_W    = DATA_W + 1;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned STOP_CNT_W = 1;

  // Reject illegal configurations at elaboration
  if (STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("transmitter: unsupported STOP_BITS/FIFO_DEPTH");
  end

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t                state, state_nx;
  logic [SHIFT_W-1:0]    shift_q, shift_nx;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nx;
  logic [STOP_CNT_W-1:0] stop_cnt, stop_cnt_nx;
  logic                  tx_nx, parity_nx;
  logic                  ready_q;
  logic                  push_c, pop_c, empty_c, head_par_c;
  logic [DATA_W-1:0]     head_c;

  assign push_c     = host.load & ready_q;
  assign host.ready = ready_q;
  assign head_par_c = ~^head_c;
  assign busy       = (state != IDLE) | ~empty_c;

`ifdef TRANSMITTER_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic              full_nx;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  always_comb begin
    wr_ptr_nx = wr_ptr + PW'(push_c);
    rd_ptr_nx = rd_ptr + PW'(pop_c);
    full_nx   = (wr_ptr_nx[AW] != rd_ptr_nx[AW]) &&
                (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]);
  end

  assign empty_c = (wr_ptr == rd_ptr);
  assign head_c  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_nx;
      rd_ptr  <= rd_ptr_nx;
      ready_q <= ~full_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= host.data_in;
  end
`else
  logic [DATA_W-1:0] hold_q;
  logic              valid_q, valid_nx;

  assign valid_nx = push_c | (valid_q & ~pop_c);
  assign empty_c  = ~valid_q;
  assign head_c   = hold_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      if (push_c) hold_q <= host.data_in;
      valid_q <= valid_nx;
      ready_q <= ~valid_nx;
    end
  end
`endif

  // Frame sequencer: everything advances only on tx_en ticks
  always_comb begin
    state_nx    = state;
    shift_nx    = shift_q;
    bit_cnt_nx  = bit_cnt;
    stop_cnt_nx = stop_cnt;
    tx_nx       = tx;
    parity_nx   = parity;
    pop_c       = 1'b0;
    if (tx_en) begin
      case (state)
        IDLE: begin
          if (!empty_c) begin
            pop_c     = 1'b1;
            shift_nx  = {head_par_c, head_c};
            parity_nx = head_par_c;
            tx_nx     = 1'b0;
            state_nx  = START;
          end else begin
            tx_nx = 1'b1;
          end
        end
        START: begin
          tx_nx      = shift_q[SHIFT_W-1];
          bit_cnt_nx = '0;
          state_nx   = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == CNT_W'(DATA_W)) begin
            tx_nx       = 1'b1;
            stop_cnt_nx = '0;
            state_nx    = STOP;
          end else begin
            shift_nx   = {shift_q[SHIFT_W-2:0], 1'b0};
            tx_nx      = shift_q[SHIFT_W-2];
            bit_cnt_nx = bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (stop_cnt == STOP_CNT_W'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when a character is waiting
            if (!empty_c) begin
              pop_c     = 1'b1;
              shift_nx  = {head_par_c, head_c};
              parity_nx = head_par_c;
              tx_nx     = 1'b0;
              state_nx  = START;
            end else begin
              tx_nx     = 1'b1;
              parity_nx = 1'b0;
              state_nx  = IDLE;
            end
          end else begin
            stop_cnt_nx = stop_cnt + STOP_CNT_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      tx       <= 1'b1;
      parity   <= 1'b0;
    end else begin
      state    <= state_nx;
      shift_q  <= shift_nx;
      bit_cnt  <= bit_cnt_nx;
      stop_cnt <= stop_cnt_nx;
      tx       <= tx_nx;
      parity   <= parity_nx;
    end
  end
endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: two instances (1 and 2 stop bits) share stimulus.
module tb_transmitter;
`ifdef TRANSMITTER_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic tx;
    logic ready;
    logic busy;
    logic parity;
  } exp_t;

  logic       clk;
  logic       resetN;
  logic       tx_en = 1'b0;
  logic       load;
  logic [6:0] data_in;
  logic       rand_tick = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         div = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit tick: every 4th cycle, or random density during the soak phase
  initial forever begin
    @(negedge clk);
    div = div + 1;
    if (rand_tick) tx_en = ($urandom_range(0, 2) == 0);
    else           tx_en = (div % 4 == 0);
  end

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int SB = k + 1;

    transmitter_if bus ();
    logic tx_w, busy_w, parity_w;
    assign bus.data_in = data_in;
    assign bus.load    = load;

    transmitter #(.STOP_BITS(SB), .FIFO_DEPTH(4)) dut (
      .clk    (clk),
      .resetN (resetN),
      .tx_en  (tx_en),
      .host   (bus.slave),
      .tx     (tx_w),
      .busy   (busy_w),
      .parity (parity_w)
    );

    logic [6:0] bufm[$];
    logic       curm[$];
    exp_t       expq[$];
    logic       in_frame, par_m, tx_m, acc;
    logic [6:0] d;
    exp_t       e, got;

    // Reference: line bits as a queue of whole frames, buffer as a character queue
    initial begin
      in_frame = 1'b0; par_m = 1'b0; tx_m = 1'b1;
      forever begin
        @(posedge clk);
        if (!resetN) begin
          bufm.delete(); curm.delete();
          in_frame = 1'b0; par_m = 1'b0; tx_m = 1'b1;
        end else begin
          acc = load && (bufm.size() < CAP);
          if (tx_en) begin
            if (curm.size() == 0 && bufm.size() != 0) begin
              d = bufm.pop_front();
              par_m = ~^d;
              in_frame = 1'b1;
              curm.push_back(1'b0);
              curm.push_back(par_m);
              for (int i = 6; i >= 0; i--) curm.push_back(d[i]);
              for (int s = 0; s < SB; s++) curm.push_back(1'b1);
            end
            if (curm.size() != 0) tx_m = curm.pop_front();
            else begin
              tx_m = 1'b1; in_frame = 1'b0; par_m = 1'b0;
            end
          end
          if (acc) bufm.push_back(data_in);
        end
        expq.push_back({tx_m, (bufm.size() < CAP), (in_frame || bufm.size() != 0), par_m});
      end
    end

    initial forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e   = expq.pop_front();
        got = {tx_w, bus.ready, busy_w, parity_w};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL stop%0d t=%0t tx/ready/busy/parity got %b want %b", SB, $time, got, e);
        end
      end
    end
  end

  task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s tx/ready/busy/parity got %b want %b", name, got, want);
    end
  endtask

  task automatic send(input logic [6:0] c);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (g_dut[0].bus.ready) begin
        load = 1'b1; data_in = c;
        @(negedge clk);
        load = 1'b0;
        return;
      end
    end
    vectors++; miscompares++;
    $display("FAIL send_timeout ready got 0 want 1");
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!g_dut[0].busy_w && !g_dut[1].busy_w) return;
    end
    vectors++; miscompares++;
    $display("FAIL idle_timeout busy got 1 want 0");
  endtask

  initial begin
    resetN = 1'b0; load = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;

    send(7'h41);
    wait_idle(300);

    send(7'h7F);
    send(7'h00);
    wait_idle(500);

    // Fill the buffer, then keep pushing 0x55 while full
    @(negedge clk);
    for (int i = 1; i <= CAP; i++) begin
      load = 1'b1; data_in = 7'(i);
      @(negedge clk);
    end
    data_in = 7'h55;
    repeat (2) @(negedge clk);
    load = 1'b0;
    wait_idle(1500);

    // Continuous load across pop edges, full and non-full
    load = 1'b1;
    repeat (60) begin
      data_in = 7'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
    wait_idle(1500);

    // Random soak with irregular ticks
    rand_tick = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      load    = ($urandom_range(0, 3) == 0);
      data_in = 7'($urandom);
    end
    load = 1'b0;
    wait_idle(3000);
    rand_tick = 1'b0;

    // Abort a frame around d3 with an asynchronous reset
    send(7'h5A);
    for (int n = 0; n < 200 && g_dut[0].tx_w; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check_now("abort_stop1", {g_dut[0].tx_w, g_dut[0].bus.ready, g_dut[0].busy_w, g_dut[0].parity_w}, 4'b1100);
    check_now("abort_stop2", {g_dut[1].tx_w, g_dut[1].bus.ready, g_dut[1].busy_w, g_dut[1].parity_w}, 4'b1100);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    send(7'h2A);
    wait_idle(300);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
